half_duplex_shifter: RTL and testbench

//  Bit-serial half-duplex controller sitting directly upstream of bidir_pin.

---
 rtl/half_duplex_pkg.sv | 22 ++
 rtl/half_duplex_shifter_bit_timer.sv | 34 +++
 rtl/half_duplex_shifter.sv | 165 ++++++++++++++++
 tb/tb_half_duplex_shifter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/half_duplex_pkg.sv
// Shared types and constants for the half-duplex bit-serial shifter.
// The optional even-parity frame bit is enabled by defining PARITY_EN.
package half_duplex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_TURN = 2'd2,
        ST_RX   = 2'd3
    } state_t;

    localparam logic DIR_DRIVE   = 1'b1;
    localparam logic DIR_RELEASE = 1'b0;

    // Width of a down-counter that must hold values 0 .. max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/half_duplex_shifter_bit_timer.sv
// Per-phase cycle down-counter: bit_end marks the last cycle of a bit period
// (or turnaround window); restart loads a new period length.
module bit_timer
    import half_duplex_pkg::*;
#(
    parameter int BIT_CYCLES  = 4,
    parameter int TURN_CYCLES = 2,
    parameter int CW          = cnt_width(BIT_CYCLES, TURN_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic [CW-1:0] load,
    output logic          bit_end,
    output logic          sample
);

    logic [CW-1:0] cnt;

    // Auto-reload keeps consecutive bit periods back to back without a restart.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (restart)
            cnt <= load;
        else if (en)
            cnt <= (cnt == '0) ? CW'(BIT_CYCLES - 1) : cnt - CW'(1);
    end

    assign bit_end = (cnt == '0);
    assign sample  = en && bit_end;

endmodule

// File: rtl/half_duplex_shifter.sv
// Half-duplex serial controller: sends one word MSB-first, optionally turns the
// line around and receives one word. Define PARITY_EN to append even parity.
module half_duplex_shifter
    import half_duplex_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BIT_CYCLES  = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rx_en,
    output logic              dir,
    output logic              data_out,
    input  logic              data_in,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              done
);

`ifdef PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_W = DATA_W + PAR_BITS;
    localparam int BW      = $clog2(FRAME_W);
    localparam int CW      = cnt_width(BIT_CYCLES, TURN_CYCLES);

    state_t             state;
    logic [FRAME_W-2:0] tx_sh;
    logic [FRAME_W-2:0] rx_sh;
    logic [FRAME_W-1:0] tx_frame;
    logic [FRAME_W-1:0] rx_frame;
    logic [BW-1:0]      bit_cnt;
    logic               rx_en_q;
    logic               accept;
    logic               last_bit;
    logic               restart;
    logic [CW-1:0]      load;
    logic               bit_end;
    logic               sample;

    assign accept   = tx_valid && tx_ready;
    assign last_bit = (bit_cnt == BW'(FRAME_W - 1));
    assign rx_frame = {rx_sh, data_in};

`ifdef PARITY_EN
    assign tx_frame = {tx_data, ^tx_data};
`else
    assign tx_frame = tx_data;
`endif

    always_comb begin
        restart = 1'b0;
        load    = CW'(BIT_CYCLES - 1);
        case (state)
            ST_IDLE: restart = accept;
            ST_TX: begin
                if (bit_end && last_bit && rx_en_q) begin
                    restart = 1'b1;
                    load    = CW'(TURN_CYCLES - 1);
                end
            end
            ST_TURN: restart = bit_end;
            default: ;
        endcase
    end

    bit_timer #(
        .BIT_CYCLES  (BIT_CYCLES),
        .TURN_CYCLES (TURN_CYCLES),
        .CW          (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (state != ST_IDLE),
        .restart (restart),
        .load    (load),
        .bit_end (bit_end),
        .sample  (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            dir      <= DIR_RELEASE;
            data_out <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_perr  <= 1'b0;
            done     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            rx_en_q  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_TX;
                        tx_ready <= 1'b0;
                        dir      <= DIR_DRIVE;
                        data_out <= tx_frame[FRAME_W-1];
                        tx_sh    <= tx_frame[FRAME_W-2:0];
                        rx_en_q  <= rx_en;
                        bit_cnt  <= '0;
                    end
                end
                ST_TX: begin
                    if (bit_end) begin
                        if (last_bit) begin
                            dir      <= DIR_RELEASE;
                            data_out <= 1'b0;
                            bit_cnt  <= '0;
                            if (rx_en_q) begin
                                state <= ST_TURN;
                            end else begin
                                state    <= ST_IDLE;
                                done     <= 1'b1;
                                tx_ready <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + BW'(1);
                            data_out <= tx_sh[FRAME_W-2];
                            tx_sh    <= tx_sh << 1;
                        end
                    end
                end
                ST_TURN: begin
                    if (bit_end)
                        state <= ST_RX;
                end
                ST_RX: begin
                    if (sample) begin
                        rx_sh <= rx_frame[FRAME_W-2:0];
                        if (last_bit) begin
                            state    <= ST_IDLE;
                            done     <= 1'b1;
                            rx_valid <= 1'b1;
                            tx_ready <= 1'b1;
                            rx_data  <= rx_frame[FRAME_W-1 -: DATA_W];
`ifdef PARITY_EN
                            rx_perr  <= ^rx_frame;
`else
                            rx_perr  <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_half_duplex_shifter.sv
// Randomized self-checking bench for half_duplex_shifter against a per-cycle
// expected-trace model built from the frame timing rules.
module tb_half_duplex_shifter;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int TC = 2;
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F = DW + PB;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          rx_en;
    logic          dir;
    logic          data_out;
    logic          data_in;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_perr;
    logic          done;

    int            errs   = 0;
    int            checks = 0;
    logic [DW-1:0] last_rx;

    half_duplex_shifter #(
        .DATA_W      (DW),
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_en    (rx_en),
        .dir      (dir),
        .data_out (data_out),
        .data_in  (data_in),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_perr  (rx_perr),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({tx_ready, dir, data_out, done, rx_valid});
    endfunction

    // Quiet idle cycles: line released, no strobes, last received word held.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = DW'($urandom);
            rx_en    = 1'($urandom);
            data_in  = 1'($urandom);
            chk("idle", ctl_vec(), 32'b10000);
            chk("idle_rx", 32'(rx_data), 32'(last_rx));
        end
    endtask

    // Enter at the negedge of a cycle where the DUT should be ready; leaves at the
    // negedge of the done cycle so the caller can hand off back to back.
    task automatic txn(input logic [DW-1:0] w, input logic rxe,
                       input logic [DW-1:0] r, input logic rp);
        logic [DW:0] tf;
        logic [DW:0] rf;
        logic        ep;
        int          tlen;
        int          r0;
        int          len;
        tf   = {w, ^w};
        rf   = {r, rp};
`ifdef PARITY_EN
        ep   = ^rf;
`else
        ep   = 1'b0;
`endif
        tlen = F * BC;
        r0   = tlen + TC + 1;
        len  = rxe ? r0 + F * BC : tlen + 1;
        chk("ready_in", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = w;
        rx_en    = rxe;
        data_in  = 1'($urandom);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            tx_valid = 1'($urandom);
            tx_data  = DW'($urandom);
            rx_en    = 1'($urandom);
            data_in  = 1'($urandom);
            if (rxe && c >= r0 && ((c - r0) % BC) == BC - 1)
                data_in = rf[DW - (c - r0) / BC];
            if (c == len) begin
                tx_valid = 1'b0;
                chk("done_cyc", ctl_vec(), 32'({1'b1, 1'b0, 1'b0, 1'b1, rxe}));
                if (rxe) begin
                    last_rx = r;
                    chk("rx_data", 32'(rx_data), 32'(r));
                    chk("rx_perr", 32'(rx_perr), 32'(ep));
                end else begin
                    chk("rx_hold", 32'(rx_data), 32'(last_rx));
                end
            end else if (c <= tlen) begin
                chk($sformatf("tx@%0d", c), ctl_vec(),
                    32'({1'b0, 1'b1, tf[DW - (c - 1) / BC], 1'b0, 1'b0}));
            end else begin
                chk($sformatf("rel@%0d", c), ctl_vec(), 32'b00000);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_en    = 1'b0;
        data_in  = 1'b0;
        last_rx  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({tx_ready, dir, data_out, done, rx_valid, rx_perr}), 32'b100000);
        chk("rst_rx", 32'(rx_data), 32'd0);
        rst = 1'b0;
        idle(2);

        // Plain TX, then a back-to-back TX handed off in the done cycle
        txn(8'hA5, 1'b0, 8'h00, 1'b0);
        txn(8'h5A, 1'b0, 8'h00, 1'b0);
        idle(1);
        txn(8'h3C, 1'b1, 8'h96, 1'b0);
        idle(1);

        // Abort a TX with reset at cycle 10
        chk("ready_abort", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        rx_en    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            chk($sformatf("abort_tx@%0d", c), ctl_vec(), 32'b01100);
        end
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        last_rx = '0;
        chk("abort_rst", ctl_vec(), 32'b10000);
        chk("abort_rx", 32'(rx_data), 32'd0);
        idle(3);
        txn(8'h01, 1'b0, 8'h00, 1'b0);
        idle(1);

`ifdef PARITY_EN
        txn(8'h07, 1'b1, 8'h01, 1'b0);
        idle(1);
`endif

        for (int i = 0; i < 24; i++) begin
            txn(DW'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
